// File: rtl/pad_scan_ctrl_pkg.sv
// Shared CNN package for the padding address generator.
// Holds the default unpadded image size, the scan FSM state encoding,
// the row-tap phase encoding and the padded-limit helper.
package pad_scan_ctrl_pkg;

   localparam int unsigned IMG_W_DEF = 64;
   localparam int unsigned IMG_H_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      PH_0 = 2'd0,
      PH_1 = 2'd1,
      PH_2 = 2'd2
   } phase_t;

   // Padded-frame limit: base + 2*pad - sub, truncated to 8 bits.
   function automatic logic [7:0] pad_limit(input int unsigned base,
                                            input logic [3:0]  pad,
                                            input int unsigned sub);
      int unsigned sum;
      sum = base + (32'(pad) * 2) - sub;
      return sum[7:0];
   endfunction

endpackage

// File: rtl/pad_scan_ctrl.sv
// Padding address generator: walks a padded frame as 3-row windows,
// emitting three row taps (phase 0/1/2) per column.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - frame-scan request (sampled in IDLE only)
//   abort           - return to IDLE, clear counters, no done pulse
//   pad_x, pad_y    - padding, latched on accepted start
//   out_ready       - downstream accepts the current tap
//   count_i/count_j - padded column / top row of current window
//   phase           - row tap within the window
//   tap_valid, busy - high in SCAN
//   done            - one-cycle pulse after the last tap is accepted
module pad_scan_ctrl
   import pad_scan_ctrl_pkg::*;
#(
   parameter int unsigned IMG_W = IMG_W_DEF,
   parameter int unsigned IMG_H = IMG_H_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] pad_x,
   input  logic [3:0] pad_y,
   input  logic       out_ready,
   output logic [6:0] count_i,
   output logic [6:0] count_j,
   output logic [1:0] phase,
   output logic       tap_valid,
   output logic       busy,
   output logic       done
);

   state_t     state_q, state_d;
   logic [3:0] pad_x_q, pad_y_q;
   logic [6:0] ci_q, cj_q;
   phase_t     ph_q;
   logic [7:0] wp, hp;
   logic       start_ok, accept, col_end, row_end, last_tap;

   assign wp       = pad_limit(IMG_W, pad_x_q, 1);
   assign hp       = pad_limit(IMG_H, pad_y_q, 3);
   assign start_ok = (state_q == ST_IDLE) && start && !abort;
   assign accept   = (state_q == ST_SCAN) && out_ready;
   assign col_end  = ({1'b0, ci_q} == wp);
   assign row_end  = ({1'b0, cj_q} == hp);
   assign last_tap = (ph_q == PH_2) && col_end && row_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start) state_d = ST_SCAN;
            ST_SCAN: if (accept && last_tap) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pad_x_q <= '0;
         pad_y_q <= '0;
      end else if (start_ok) begin
         pad_x_q <= pad_x;
         pad_y_q <= pad_y;
      end
   end

   // Counters clear whenever not scanning; since DONE is only entered on
   // the last accept (which holds them), DONE still shows the final tap
   // and IDLE reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph_q <= PH_0;
      end else if (abort || state_q != ST_SCAN) begin
         ph_q <= PH_0;
      end else if (accept && !last_tap) begin
         case (ph_q)
            PH_0:    ph_q <= PH_1;
            PH_1:    ph_q <= PH_2;
            default: ph_q <= PH_0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ci_q <= '0;
      end else if (abort || state_q != ST_SCAN) begin
         ci_q <= '0;
      end else if (accept && ph_q == PH_2 && !last_tap) begin
         ci_q <= col_end ? '0 : ci_q + 7'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cj_q <= '0;
      end else if (abort || state_q != ST_SCAN) begin
         cj_q <= '0;
      end else if (accept && ph_q == PH_2 && col_end && !row_end) begin
         cj_q <= cj_q + 7'd1;
      end
   end

   assign count_i   = ci_q;
   assign count_j   = cj_q;
   assign phase     = ph_q;
   assign tap_valid = (state_q == ST_SCAN);
   assign busy      = (state_q == ST_SCAN);
   assign done      = (state_q == ST_DONE);

endmodule

// File: doc/pad_scan_ctrl.md
PAD_SCAN_CTRL -- requirements
Module: pad_scan_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 64, meaning unpadded image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 64, meaning unpadded image height in pixels.
REQ-003 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1, frame-scan request, sampled in IDLE only.
REQ-006 The block SHALL have port abort, input, 1, terminates the scan and returns to IDLE.
REQ-007 The block SHALL have port pad_x, input, 4, horizontal padding, latched on accepted start.
REQ-008 The block SHALL have port pad_y, input, 4, vertical padding, latched on accepted start.
REQ-009 The block SHALL have port out_ready, input, 1, downstream accepts the current tap.
REQ-010 The block SHALL have port count_i, output, 7, padded-frame column of the current window.
REQ-011 The block SHALL have port count_j, output, 7, padded-frame top row of the current 3-row window.
REQ-012 The block SHALL have port phase, output, 2, row tap within the window: 0, 1 or 2.
REQ-013 The block SHALL have port tap_valid, output, 1, count_i/count_j/phase are valid this cycle.
REQ-014 The block SHALL have port busy, output, 1, high in SCAN.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse after the last tap is accepted.

Function
REQ-016 The block SHALL implement states IDLE, SCAN, DONE.
REQ-017 IDLE SHALL go to SCAN when start=1 and abort=0, latching pad_x/pad_y and clearing count_i, count_j and phase.
REQ-018 Column limit SHALL be WP = IMG_W + 2*pad_x - 1; row limit SHALL be HP = IMG_H + 2*pad_y - 3; both use latched pads and are computed 8 bits wide.
REQ-019 In SCAN, tap_valid SHALL be 1; a tap is accepted when tap_valid=1 and out_ready=1.
REQ-020 On acceptance, phase SHALL advance 0->1->2; at phase 2 it SHALL return to 0 and count_i SHALL increment.
REQ-021 On acceptance at phase 2 with count_i=WP, count_i SHALL wrap to 0 and count_j SHALL increment.
REQ-022 On acceptance at phase 2 with count_i=WP and count_j=HP, the block SHALL go to DONE with all counters held.
REQ-023 With out_ready=0, count_i, count_j and phase SHALL hold indefinitely.
REQ-024 DONE SHALL assert done=1 for exactly one cycle and go to IDLE on the next edge.
REQ-025 abort=1 in any state SHALL force IDLE on the next edge, clear the counters and suppress done; abort takes priority over start and acceptance.
REQ-026 start in SCAN or DONE SHALL be ignored, and pad_x/pad_y changes during SCAN SHALL NOT affect the scan.
REQ-027 Outside SCAN, tap_valid=0 and busy=0; count_i, count_j and phase SHALL read 0 in IDLE.
REQ-028 Outputs SHALL be registered; the first tap (0,0,0) SHALL appear the cycle after start is accepted.
REQ-029 Total accepted taps per frame SHALL equal 3*(WP+1)*(HP+1).

Reset
REQ-030 On rst=1 the block SHALL enter IDLE immediately, with count_i=0, count_j=0, phase=0, tap_valid=0, busy=0, done=0 and the latched pads at 0.
REQ-031 rst mid-scan SHALL discard the frame with no done pulse; a new start is required after rst deasserts.

Structure
REQ-032 The state encoding, the phase encoding (0/1/2) and default IMG_W/IMG_H SHALL live in the shared CNN package, used by the padding address generator.
REQ-033 The block SHALL be a single module with no sub-modules; the counter/limit logic MAY be one internal always block per counter.

Verification
REQ-034 pad_x=1, pad_y=1, out_ready=1, start pulse -> 3*66*64=12672 taps, last tap (65,63,2), done one cycle later, busy low after.
REQ-035 pad_x=0, pad_y=0 -> first tap (0,0,0); final tap (63,61,2); count_i wraps 63->0 with count_j 0->1.
REQ-036 out_ready low for 5 cycles at tap (10,3,1) -> outputs hold (10,3,1) for all 5 cycles; then the scan resumes at (10,3,2).
REQ-037 abort at tap (20,5,0) -> IDLE next cycle, all outputs 0, no done pulse; a following start restarts at (0,0,0).
REQ-038 start re-pulsed and pad_x changed 1->4 mid-scan -> no restart; WP stays 65.
REQ-039 rst asserted mid-scan -> outputs 0 asynchronously, no done pulse; after release, IDLE until start.
